// File: rtl/sum_uart_tx.sv
// Buffered 8N1 UART transmitter: a byte FIFO fed by the column-sum strobe
// stream and drained one frame at a time onto the serial line.
module sum_uart_tx #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       pi_flag,
  input  logic [7:0] pi_data,
  output logic       tx,
  output logic       busy,
  output logic       ovf_flag
);

  localparam int unsigned BAUD_CNT_MAX = CLK_FREQ / BAUD;
  localparam int unsigned CW           = $clog2(BAUD_CNT_MAX);
  localparam int unsigned AW           = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTW         = AW + 1;

  localparam logic [CW-1:0]   BAUD_LAST = CW'(BAUD_CNT_MAX - 1);
  localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_baud_cnt;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic            r_tx;
  logic            r_busy;
  logic            r_ovf;

  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CNTW-1:0] r_count;

  logic w_bit_end;
  logic w_full;
  logic w_nonempty;
  logic w_push;
  logic w_pop;

  // Fullness is judged on the pre-edge count, so a same-cycle pop never
  // rescues a push into a full FIFO.
  always_comb begin
    w_bit_end  = (r_baud_cnt == BAUD_LAST);
    w_full     = (r_count == FULL_CNT);
    w_nonempty = (r_count != '0);
    w_push     = pi_flag && !w_full;
    w_pop      = w_nonempty &&
                 ((r_state == IDLE) || ((r_state == STOP) && w_bit_end));
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst && w_push) begin
      r_mem[r_wr_ptr] <= pi_data;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_ovf <= pi_flag && w_full;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // tx and busy are set from the state being entered, so both line up with
  // the edge that begins or ends a frame.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state    <= IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_baud_cnt <= '0;
          r_bit_idx  <= '0;
          if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
            r_state <= START;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
          end else begin
            r_tx   <= 1'b1;
            r_busy <= 1'b0;
          end
        end

        START: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_state    <= DATA;
            r_tx       <= r_shift[0];
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_state <= STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= r_shift[r_bit_idx + 3'd1];
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end

        STOP: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            if (w_pop) begin
              r_shift <= r_mem[r_rd_ptr];
              r_state <= START;
              r_tx    <= 1'b0;
            end else begin
              r_state <= IDLE;
              r_tx    <= 1'b1;
              r_busy  <= 1'b0;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign tx       = r_tx;
  assign busy     = r_busy;
  assign ovf_flag = r_ovf;

endmodule

// File: tb/tb_sum_uart_tx.sv
// Directed bench for sum_uart_tx at 10 clocks per bit: frame timing, bursts,
// overflow, the full-FIFO boundary and resets mid-frame / during a write.
module tb_sum_uart_tx;

  logic       clk;
  logic       sys_rst;
  logic       pi_flag;
  logic [7:0] pi_data;
  logic       tx;
  logic       busy;
  logic       ovf_flag;

  int unsigned n_chk;
  int unsigned n_pass;

  int unsigned cyc;
  int unsigned ovf_cnt;
  int unsigned ovf_cyc;
  int unsigned txlow_cnt;

  // {flag, data} per cycle; entries with flag 0 act as idle spacers
  logic [8:0] q [$];

  sum_uart_tx #(
    .CLK_FREQ  (50_000_000),
    .BAUD      (5_000_000),
    .FIFO_DEPTH(8)
  ) dut (
    .sys_clk (clk),
    .sys_rst (sys_rst),
    .pi_flag (pi_flag),
    .pi_data (pi_data),
    .tx      (tx),
    .busy    (busy),
    .ovf_flag(ovf_flag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ovf_flag) begin
      ovf_cnt = ovf_cnt + 1;
      ovf_cyc = cyc;
    end
    if (!tx) txlow_cnt = txlow_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    logic [8:0] e;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e       = q.pop_front();
        pi_flag = e[8];
        pi_data = e[7:0];
      end else begin
        pi_flag = 1'b0;
      end
    end
  endtask

  task automatic qpush(input logic f, input logic [7:0] d);
    q.push_back({f, d});
  endtask

  // Called at the sample point just after the edge that starts the start bit;
  // returns at the same point of the following bit slot.
  task automatic check_frame(input logic [7:0] b, input string tag);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("%s_bit%0d_first", tag, k), 32'(tx), 32'(fr[k]));
      chk($sformatf("%s_busy%0d", tag, k), 32'(busy), 32'd1);
      tick(9);
      chk($sformatf("%s_bit%0d_last", tag, k), 32'(tx), 32'(fr[k]));
      tick(1);
    end
  endtask

  initial begin
    int unsigned e1;
    int unsigned ovf0;
    int unsigned low0;

    n_chk     = 0;
    n_pass    = 0;
    cyc       = 0;
    ovf_cnt   = 0;
    ovf_cyc   = 0;
    txlow_cnt = 0;
    sys_rst   = 1'b1;
    pi_flag   = 1'b0;
    pi_data   = 8'h00;

    tick(3);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(ovf_flag), 32'd0);
    sys_rst = 1'b0;

    // single byte 0xA5
    ovf0 = ovf_cnt;
    qpush(1'b1, 8'hA5);
    tick(1);
    chk("s1_pre_tx", 32'(tx), 32'd1);
    tick(1);
    chk("s1_write_tx", 32'(tx), 32'd1);
    chk("s1_write_busy", 32'(busy), 32'd0);
    tick(1);
    check_frame(8'hA5, "s1");
    chk("s1_end_tx", 32'(tx), 32'd1);
    chk("s1_end_busy", 32'(busy), 32'd0);
    chk("s1_no_ovf", ovf_cnt - ovf0, 32'd0);

    // burst of three contiguous frames
    qpush(1'b1, 8'h01);
    qpush(1'b1, 8'h02);
    qpush(1'b1, 8'h03);
    tick(3);
    check_frame(8'h01, "b1");
    check_frame(8'h02, "b2");
    check_frame(8'h03, "b3");
    chk("burst_end_busy", 32'(busy), 32'd0);
    chk("burst_end_tx", 32'(tx), 32'd1);

    // overflow: 10 bytes, the 10th is dropped
    ovf0 = ovf_cnt;
    for (int i = 0; i < 10; i++) qpush(1'b1, 8'(8'h10 + i));
    tick(3);
    e1 = cyc;
    for (int i = 0; i < 9; i++) check_frame(8'(8'h10 + i), $sformatf("ov%0d", i));
    chk("ov_end_busy", 32'(busy), 32'd0);
    chk("ov_pulses", ovf_cnt - ovf0, 32'd1);
    chk("ov_pulse_cyc", ovf_cyc, e1 + 8);

    // full boundary: push on the STOP-end edge that also pops
    ovf0 = ovf_cnt;
    for (int i = 0; i < 9; i++) qpush(1'b1, 8'(8'hA0 + i));
    for (int i = 9; i < 101; i++) qpush(1'b0, 8'h00);
    qpush(1'b1, 8'h55);
    qpush(1'b1, 8'h66);
    tick(3);
    e1 = cyc;
    for (int i = 0; i < 9; i++) check_frame(8'(8'hA0 + i), $sformatf("fb%0d", i));
    check_frame(8'h66, "fb66");
    chk("fb_end_busy", 32'(busy), 32'd0);
    chk("fb_pulses", ovf_cnt - ovf0, 32'd1);
    chk("fb_pulse_cyc", ovf_cyc, e1 + 100);

    // reset mid-frame during data bit 4 with two bytes queued
    qpush(1'b1, 8'hEF);
    qpush(1'b1, 8'h12);
    qpush(1'b1, 8'h34);
    tick(3);
    chk("rm_start_tx", 32'(tx), 32'd0);
    tick(54);
    chk("rm_bit4_tx", 32'(tx), 32'd0);
    sys_rst = 1'b1;
    tick(1);
    sys_rst = 1'b0;
    chk("rm_rst_tx", 32'(tx), 32'd1);
    chk("rm_rst_busy", 32'(busy), 32'd0);
    low0 = txlow_cnt;
    tick(250);
    chk("rm_silent", txlow_cnt - low0, 32'd0);
    chk("rm_idle_busy", 32'(busy), 32'd0);
    qpush(1'b1, 8'h3C);
    tick(3);
    check_frame(8'h3C, "rm3c");
    chk("rm_end_busy", 32'(busy), 32'd0);

    // pi_flag coincident with reset is ignored
    qpush(1'b1, 8'h77);
    tick(1);
    sys_rst = 1'b1;
    tick(1);
    sys_rst = 1'b0;
    chk("rw_tx", 32'(tx), 32'd1);
    chk("rw_busy", 32'(busy), 32'd0);
    low0 = txlow_cnt;
    tick(20);
    chk("rw_silent", txlow_cnt - low0, 32'd0);
    chk("rw_idle_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sum_uart_tx.md
# sum_uart_tx

Buffered UART transmitter that sits directly downstream of the FIFO column-sum stage. It accepts the `po_flag`/`po_data` byte stream from that stage on its `pi_flag`/`pi_data` inputs and holds the bytes in an internal byte FIFO. It serialises each byte as an 8N1 UART frame to the PC link. The FIFO absorbs bursts of sums that arrive faster than the line rate.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD`, 9600: line rate. `BAUD_CNT_MAX = CLK_FREQ/BAUD` (integer division) is the number of clocks per bit; must be ≥ 2.
- `FIFO_DEPTH`, 8: byte FIFO depth; power of two, ≥ 2.

Ports:
- `sys_clk`  in  1  system clock; all logic on the rising edge.
- `sys_rst`  in  1  synchronous, active-high reset.
- `pi_flag`  in  1  one-cycle strobe; `pi_data` valid.
- `pi_data`  in  8  byte to transmit.
- `tx`  out  1  UART serial line, idle high.
- `busy`  out  1  high while the FIFO is non-empty or a frame is in progress.
- `ovf_flag`  out  1  one-cycle pulse when an input byte is dropped.

## Operation
- **Reset.** `tx`=1, `busy`=0, `ovf_flag`=0. FIFO empty, state IDLE, baud and bit counters 0. Reset mid-frame aborts the frame: `tx`=1 after the reset edge and FIFO contents are discarded.
- **Write.**
  - A byte is accepted on a cycle with `pi_flag`=1 and FIFO count < `FIFO_DEPTH`, where count is the value before that edge.
  - When count == `FIFO_DEPTH`, the byte is dropped, even if a pop occurs in the same cycle. `ovf_flag` is high for exactly the next cycle.
  - A push and a pop in the same cycle leave the count unchanged.
- **States.** IDLE, START, DATA, STOP. The baud counter runs 0..`BAUD_CNT_MAX`-1 in every non-IDLE state. A bit ends when the counter reaches `BAUD_CNT_MAX`-1.
- **IDLE.**
  - `tx`=1.
  - If the FIFO is non-empty: pop the head byte into the shift register, reset the baud counter, go to START.
- **START.** `tx`=0 for one bit time, then go to DATA with bit index 0.
- **DATA.**
  - `tx` = shift register bit `[index]`, LSB first.
  - At each bit end, index increments. After index 7 ends, go to STOP.
- **STOP.**
  - `tx`=1 for one bit time.
  - At the bit end: if the FIFO is non-empty, pop and go directly to START (no idle cycle between frames); otherwise go to IDLE.
- **Frame length.** Exactly 10 × `BAUD_CNT_MAX` clocks.
- **Counters.**
  - Baud counter width `$clog2(BAUD_CNT_MAX)`.
  - FIFO pointers wrap modulo `FIFO_DEPTH`.
  - Count width `$clog2(FIFO_DEPTH)+1`.
- **Busy.** `busy` = (state != IDLE) || (count != 0), registered.

## Timing
- **`tx` output.** Registered; changes only on `sys_clk` rising edges.
- **Latency.** With the FIFO empty and state IDLE, a `pi_flag` sampled at edge E0 is written at E0. IDLE pops at E1, and `tx` goes low at E1 (1 clock from write to start bit).
- **`busy` rise.** `busy` rises at E1 and falls at the edge ending the last STOP bit when the FIFO is empty.
- **Back-to-back.** With the FIFO non-empty at STOP end, consecutive frames are contiguous with no gap.
- **Input rate.** `pi_flag` may be asserted every cycle; there is no backpressure to upstream; excess bytes are dropped and flagged.

## Test plan
Use `CLK_FREQ`=50_000_000 and `BAUD`=5_000_000 (10 clocks/bit) for all scenarios.
- **Single byte.** After reset, one `pi_flag` with 0xA5 → `tx` low 1 clock later. Then 10-clock bits 0,1,0,1,0,0,1,0,1,1 (start, b0..b7, stop). `busy` is high for 100 clocks and `ovf_flag` stays 0.
- **Burst.** 0x01, 0x02, 0x03 on three consecutive cycles → three contiguous frames totalling 300 clocks. Data LSB-first is correct and there is no idle gap between frames.
- **Overflow.** 10 bytes 0x10..0x19 on consecutive cycles from empty/IDLE → 0x10..0x18 transmitted in order and 0x19 dropped. A single `ovf_flag` pulse appears one cycle after the 10th `pi_flag`.
- **Full boundary.**
  - Fill the FIFO to 8 during a frame.
  - Push 0x55 on the cycle STOP ends with a pop → 0x55 dropped and `ovf_flag` pulses.
  - Next push 0x66 → accepted.
- **Reset mid-frame.** Assert `sys_rst` for 1 clock during DATA bit 4 with 2 bytes queued → `tx`=1 next edge, `busy`=0, and no further frames. A new byte 0x3C is then sent correctly.
- **Reset during write.** `pi_flag` is coincident with `sys_rst` → byte ignored and FIFO empty after reset.
